// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand-classification front end:
// op codes, class-vector and FCLASS bit positions, canonical constants.
package fpu_pkg;

    localparam int FCLASS_W = 10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_FMA = 3'b011;
    localparam logic [2:0] OP_FMS = 3'b100;

    // Class vector layout {snan, nan, inf, zero, subnormal}
    localparam int CLS_SNAN = 4;
    localparam int CLS_NAN  = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 1;
    localparam int CLS_SUB  = 0;

    localparam logic [31:0] QNAN_POS = 32'h7FC0_0000;
    localparam logic [31:0] INF_POS  = 32'h7F80_0000;
    localparam logic [31:0] INF_NEG  = 32'hFF80_0000;

    localparam int FC_NEG_INF  = 0;
    localparam int FC_NEG_NORM = 1;
    localparam int FC_NEG_SUB  = 2;
    localparam int FC_NEG_ZERO = 3;
    localparam int FC_POS_ZERO = 4;
    localparam int FC_POS_SUB  = 5;
    localparam int FC_POS_NORM = 6;
    localparam int FC_POS_INF  = 7;
    localparam int FC_SNAN     = 8;
    localparam int FC_QNAN     = 9;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  op;
    } s1_t;

    function automatic logic op_defined(input logic [2:0] op);
        return op <= OP_FMS;
    endfunction

endpackage

// File: rtl/fpu_class_unit.sv
// Combinational classification of one single-precision operand.
// With FPU_CLASSIFY_FTZ_EN defined, subnormals are flushed to signed zero.
module fpu_class_unit
    import fpu_pkg::*;
#(
    parameter int CLS_W = 5
) (
    input  logic [31:0]         a,
    output logic [CLS_W-1:0]    cls,
    output logic [FCLASS_W-1:0] fclass,
    output logic [31:0]         a_out
);

    logic       sign;
    logic [7:0] e;
    logic [22:0] f;
    logic       e_max, e_min, f_zero, flush;
    logic       nan, snan, inf, zero, sub, normal;

    assign sign   = a[31];
    assign e      = a[30:23];
    assign f      = a[22:0];
    assign e_max  = (e == 8'hFF);
    assign e_min  = (e == 8'h00);
    assign f_zero = (f == 23'd0);

`ifdef FPU_CLASSIFY_FTZ_EN
    assign flush = e_min & ~f_zero;
`else
    assign flush = 1'b0;
`endif

    assign a_out  = flush ? {sign, 31'd0} : a;
    assign nan    = e_max & ~f_zero;
    assign snan   = nan & ~f[22];
    assign inf    = e_max & f_zero;
    assign zero   = e_min & (f_zero | flush);
    assign sub    = e_min & ~f_zero & ~flush;
    assign normal = ~e_max & ~e_min;

    always_comb begin
        cls           = '0;
        cls[CLS_SNAN] = snan;
        cls[CLS_NAN]  = nan;
        cls[CLS_INF]  = inf;
        cls[CLS_ZERO] = zero;
        cls[CLS_SUB]  = sub;

        fclass              = '0;
        fclass[FC_NEG_INF]  = inf & sign;
        fclass[FC_NEG_NORM] = normal & sign;
        fclass[FC_NEG_SUB]  = sub & sign;
        fclass[FC_NEG_ZERO] = zero & sign;
        fclass[FC_POS_ZERO] = zero & ~sign;
        fclass[FC_POS_SUB]  = sub & ~sign;
        fclass[FC_POS_NORM] = normal & ~sign;
        fclass[FC_POS_INF]  = inf & ~sign;
        fclass[FC_SNAN]     = snan;
        fclass[FC_QNAN]     = nan & ~snan;
    end

endmodule

// File: rtl/fpu_operand_classify.sv
// Two-stage valid/ready FPU front end: registers operands, then registers
// per-operand classes, FCLASS of x and the early invalid/NV flags.
// Optional subnormal flush-to-zero via FPU_CLASSIFY_FTZ_EN.
module fpu_operand_classify
    import fpu_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int CLS_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_x,
    input  logic [31:0]         in_y,
    input  logic [31:0]         in_z,
    input  logic [2:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_x,
    output logic [31:0]         out_y,
    output logic [31:0]         out_z,
    output logic [2:0]          out_op,
    output logic [CLS_W-1:0]    x_cls,
    output logic [CLS_W-1:0]    y_cls,
    output logic [CLS_W-1:0]    z_cls,
    output logic                invalid_op,
    output logic                nv_flag,
    output logic [FCLASS_W-1:0] x_fclass
);

    if (STAGES != 2) begin : g_unsupported_stages
        $error("fpu_operand_classify supports only STAGES=2");
    end

    logic v1, v2;
    s1_t  s1;
    logic s1_load, s2_load;

    assign s2_load   = ~v2 | out_ready;
    assign s1_load   = ~v1 | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1 <= '{x: in_x, y: in_y, z: in_z, op: in_op};
            end
        end
    end

    logic [CLS_W-1:0]    xc, yc, zc;
    logic [FCLASS_W-1:0] xf, yf_unused, zf_unused;
    logic [31:0]         xo, yo, zo;

    fpu_class_unit #(.CLS_W(CLS_W)) u_cls_x (.a(s1.x), .cls(xc), .fclass(xf),        .a_out(xo));
    fpu_class_unit #(.CLS_W(CLS_W)) u_cls_y (.a(s1.y), .cls(yc), .fclass(yf_unused), .a_out(yo));
    fpu_class_unit #(.CLS_W(CLS_W)) u_cls_z (.a(s1.z), .cls(zc), .fclass(zf_unused), .a_out(zo));

    logic                op_ok, use_z, any_nan, prod_0inf, inv_raw;
    logic                inv_c, nv_c;
    logic                xs, ys, zs;
    logic [CLS_W-1:0]    xc_m, yc_m, zc_m;
    logic [FCLASS_W-1:0] xf_m;

    assign xs = s1.x[31];
    assign ys = s1.y[31];
    assign zs = s1.z[31];

    always_comb begin
        op_ok     = op_defined(s1.op);
        use_z     = (s1.op == OP_FMA) | (s1.op == OP_FMS);
        xc_m      = op_ok ? xc : '0;
        yc_m      = op_ok ? yc : '0;
        zc_m      = use_z ? zc : '0;
        xf_m      = op_ok ? xf : '0;
        any_nan   = xc[CLS_NAN] | yc[CLS_NAN] | (use_z & zc[CLS_NAN]);
        prod_0inf = (xc[CLS_INF] & yc[CLS_ZERO]) | (xc[CLS_ZERO] & yc[CLS_INF]);

        // Effective-subtraction of infinities: compare product sign against
        // the sign z actually contributes after the FMS/SUB negation.
        inv_raw = 1'b0;
        case (s1.op)
            OP_ADD, OP_SUB:
                inv_raw = xc[CLS_INF] & yc[CLS_INF] & (xs ^ ys ^ (s1.op == OP_SUB));
            OP_MUL:
                inv_raw = prod_0inf;
            OP_FMA, OP_FMS:
                inv_raw = prod_0inf
                        | ((xc[CLS_INF] | yc[CLS_INF]) & zc[CLS_INF]
                           & ((xs ^ ys) ^ (zs ^ (s1.op == OP_FMS))));
            default:
                inv_raw = 1'b0;
        endcase

        inv_c = inv_raw & ~any_nan;
        nv_c  = inv_c | xc_m[CLS_SNAN] | yc_m[CLS_SNAN] | zc_m[CLS_SNAN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
            out_op     <= '0;
            x_cls      <= '0;
            y_cls      <= '0;
            z_cls      <= '0;
            invalid_op <= 1'b0;
            nv_flag    <= 1'b0;
            x_fclass   <= '0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                out_x      <= xo;
                out_y      <= yo;
                out_z      <= zo;
                out_op     <= s1.op;
                x_cls      <= xc_m;
                y_cls      <= yc_m;
                z_cls      <= zc_m;
                invalid_op <= inv_c;
                nv_flag    <= nv_c;
                x_fclass   <= xf_m;
            end
        end
    end

endmodule

// File: tb/tb_fpu_operand_classify.sv
// Randomized and directed bench for fpu_operand_classify with an
// IEEE-category reference model and an in-order expectation queue.
module tb_fpu_operand_classify;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_x = '0, in_y = '0, in_z = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_x, out_y, out_z;
    logic [2:0]  out_op;
    logic [4:0]  x_cls, y_cls, z_cls;
    logic        invalid_op, nv_flag;
    logic [9:0]  x_fclass;

    always #5 clk = ~clk;

    fpu_operand_classify dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_op(out_op),
        .x_cls(x_cls), .y_cls(y_cls), .z_cls(z_cls),
        .invalid_op(invalid_op), .nv_flag(nv_flag), .x_fclass(x_fclass)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  op;
        logic [4:0]  xc;
        logic [4:0]  yc;
        logic [4:0]  zc;
        logic        inv;
        logic        nv;
        logic [9:0]  fc;
    } res_t;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Categories numbered in FCLASS bit order
    localparam int C_NINF = 0, C_NNORM = 1, C_NSUB = 2, C_NZERO = 3, C_PZERO = 4;
    localparam int C_PSUB = 5, C_PNORM = 6, C_PINF = 7, C_SNAN = 8, C_QNAN = 9;

    logic [31:0] specials [12] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                   32'h7FC0_0000, 32'h7F80_0001, 32'hFFA0_0000, 32'h0000_0001,
                                   32'h807F_FFFF, 32'h3F80_0000, 32'hBF80_0000, 32'hFFC0_0000};

    function automatic int cat_of(input logic [31:0] a);
        logic neg = a[31];
        int   ex  = int'(a[30:23]);
        if (ex == 255) begin
            if (a[22:0] == 0) return neg ? C_NINF : C_PINF;
            return a[22] ? C_QNAN : C_SNAN;
        end
        if (ex == 0) begin
            if (a[22:0] == 0) return neg ? C_NZERO : C_PZERO;
`ifdef FPU_CLASSIFY_FTZ_EN
            return neg ? C_NZERO : C_PZERO;
`else
            return neg ? C_NSUB : C_PSUB;
`endif
        end
        return neg ? C_NNORM : C_PNORM;
    endfunction

    function automatic logic [31:0] flushed(input logic [31:0] a);
`ifdef FPU_CLASSIFY_FTZ_EN
        if (a[30:23] == 0 && a[22:0] != 0) return {a[31], 31'd0};
`endif
        return a;
    endfunction

    function automatic logic is_inf(input int c);  return c == C_NINF || c == C_PINF;   endfunction
    function automatic logic is_zero(input int c); return c == C_NZERO || c == C_PZERO; endfunction
    function automatic logic is_nan(input int c);  return c == C_SNAN || c == C_QNAN;   endfunction

    function automatic logic [4:0] cls_of(input int c);
        return {c == C_SNAN, is_nan(c), is_inf(c), is_zero(c), c == C_NSUB || c == C_PSUB};
    endfunction

    function automatic res_t model(input logic [31:0] x, y, z, input logic [2:0] op);
        res_t r = '0;
        int   cx = cat_of(x), cy = cat_of(y), cz = cat_of(z);
        logic use_z = (op == 3'd3 || op == 3'd4);
        logic mul0inf, anynan;
        r.x = flushed(x); r.y = flushed(y); r.z = flushed(z); r.op = op;
        if (op > 3'd4) return r;
        r.xc = cls_of(cx);
        r.yc = cls_of(cy);
        if (use_z) r.zc = cls_of(cz);
        r.fc = 10'd1 << cx;
        mul0inf = (is_inf(cx) && is_zero(cy)) || (is_zero(cx) && is_inf(cy));
        anynan  = is_nan(cx) || is_nan(cy) || (use_z && is_nan(cz));
        if (op <= 3'd1)
            r.inv = is_inf(cx) && is_inf(cy) && (x[31] != (y[31] ^ (op == 3'd1)));
        else if (op == 3'd2)
            r.inv = mul0inf;
        else
            r.inv = mul0inf || ((is_inf(cx) || is_inf(cy)) && is_inf(cz)
                                && ((x[31] ^ y[31]) != (z[31] ^ (op == 3'd4))));
        if (anynan) r.inv = 1'b0;
        r.nv = r.inv || cx == C_SNAN || cy == C_SNAN || (use_z && cz == C_SNAN);
        return r;
    endfunction

    function automatic res_t sample();
        return '{x: out_x, y: out_y, z: out_z, op: out_op, xc: x_cls, yc: y_cls,
                 zc: z_cls, inv: invalid_op, nv: nv_flag, fc: x_fclass};
    endfunction

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(0, 1) == 0) return specials[$urandom_range(0, 11)];
        return $urandom;
    endfunction

    // Per-cycle bookkeeping filled by step(); callers do the comparisons
    logic last_ir, last_ov, last_fire, last_acc;
    res_t last_got, last_exp;

    task automatic step(input logic v, input logic [31:0] x, y, z, input logic [2:0] op,
                        input logic rdy);
        @(negedge clk);
        in_valid = v; in_x = x; in_y = y; in_z = z; in_op = op; out_ready = rdy;
        #1;
        last_ir   = in_ready;
        last_ov   = out_valid;
        last_fire = out_valid && rdy;
        last_acc  = v && in_ready;
        last_got  = sample();
        last_exp  = 'x;
        if (last_fire && exp_q.size() > 0) last_exp = exp_q.pop_front();
        if (last_acc) exp_q.push_back(model(x, y, z, op));
    endtask

    // Isolated transaction: out_valid must be low one cycle after accept, high after two
    task automatic run_one(input logic [31:0] x, y, z, input logic [2:0] op,
                           output logic early, output logic late, output res_t got,
                           output res_t exp);
        step(1'b1, x, y, z, op, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1);
        early = last_ov;
        step(1'b0, '0, '0, '0, '0, 1'b1);
        late = last_fire;
        got  = last_got;
        exp  = last_exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({out_valid, sample()} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%0b res=%h, want all zero", out_valid, sample());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic e, l;
        res_t g, m;
        logic [31:0] xs [9] = '{32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000,
                                32'h7F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'h0000_0001,
                                32'h7F80_0000};
        logic [31:0] ys [9] = '{32'hFF80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000,
                                32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                32'hFF80_0000};
        logic [31:0] zs [9] = '{32'h0, 32'h0, 32'h0, 32'hFF80_0000, 32'hFF80_0000,
                                32'h0, 32'h0, 32'h0, 32'h0};
        logic [2:0]  ops [9] = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd5};
        // Expected {xc, yc, inv, nv}
        logic [11:0] want [9] = '{{5'b00100, 5'b00100, 2'b11}, {5'b00010, 5'b00100, 2'b11},
                                  {5'b00000, 5'b00100, 2'b00}, {5'b00100, 5'b00000, 2'b11},
                                  {5'b00100, 5'b00000, 2'b00}, {5'b11000, 5'b00000, 2'b01},
                                  {5'b01000, 5'b00000, 2'b00}, {5'b00000, 5'b00000, 2'b00},
                                  {5'b00000, 5'b00000, 2'b00}};
        logic [9:0]  want_fc [9] = '{10'h080, 10'h010, 10'h040, 10'h080, 10'h080,
                                     10'h100, 10'h200, 10'h000, 10'h000};
`ifdef FPU_CLASSIFY_FTZ_EN
        want[7] = {5'b00010, 5'b00000, 2'b00};
        want_fc[7] = 10'h010;
`else
        want[7] = {5'b00001, 5'b00000, 2'b00};
        want_fc[7] = 10'h020;
`endif
        for (int i = 0; i < 9; i++) begin
            run_one(xs[i], ys[i], zs[i], ops[i], e, l, g, m);
            n_tests++;
            if ({e, l} !== 2'b01) begin
                n_fail++;
                $display("FAIL latency_%0d: got early=%0b at2=%0b, want 0/1", i, e, l);
            end
            n_tests++;
            if ({g.xc, g.yc, g.inv, g.nv} !== want[i] || g.fc !== want_fc[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got cls/flags=%b fclass=%b, want %b %b",
                         i, {g.xc, g.yc, g.inv, g.nv}, g.fc, want[i], want_fc[i]);
            end
            n_tests++;
            if (g !== m) begin
                n_fail++;
                $display("FAIL directed_model_%0d: got %h, want %h", i, g, m);
            end
        end
        run_one(32'h0000_0001, 32'h0, 32'h0, 3'd0, e, l, g, m);
        n_tests++;
`ifdef FPU_CLASSIFY_FTZ_EN
        if (g.x !== 32'h0000_0000) begin
`else
        if (g.x !== 32'h0000_0001) begin
`endif
            n_fail++;
            $display("FAIL subnormal_out_x: got %h", g.x);
        end
    endtask

    task automatic test_back_to_back();
        res_t a_hold;
        logic [31:0] ax = 32'h7F80_0000, bx = 32'h3F80_0000, cx = 32'h7F80_0001;
        step(1'b1, ax, 32'hFF80_0000, 32'h0, 3'd0, 1'b1);
        step(1'b1, bx, 32'h0, 32'h7F80_0000, 3'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, cx, 32'h0000_0001, 32'h0, 3'd2, 1'b0);
            if (c == 0) a_hold = last_got;
            n_tests++;
            if (last_ir !== 1'b0 || last_ov !== 1'b1 || last_got !== a_hold) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got in_ready=%0b ov=%0b out=%h, want 0/1 %h",
                         c, last_ir, last_ov, last_got, a_hold);
            end
        end
        n_tests++;
        if (a_hold.x !== ax) begin
            n_fail++;
            $display("FAIL stall_is_a: got out_x=%h, want %h", a_hold.x, ax);
        end
        step(1'b1, cx, 32'h0000_0001, 32'h0, 3'd2, 1'b1);
        n_tests++;
        if (last_ir !== 1'b1 || !last_fire || last_got !== last_exp) begin
            n_fail++;
            $display("FAIL b2b_a: got ir=%0b fire=%0b out=%h, want 1/1 %h",
                     last_ir, last_fire, last_got, last_exp);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, '0, '0, '0, '0, 1'b1);
            n_tests++;
            if (!last_fire || last_got !== last_exp || last_got.x !== (k == 0 ? bx : cx)) begin
                n_fail++;
                $display("FAIL b2b_order_%0d: got fire=%0b out=%h, want %h",
                         k, last_fire, last_got, last_exp);
            end
        end
        step(1'b0, '0, '0, '0, '0, 1'b1);
        n_tests++;
        if (last_ov !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_no_dup: got ov=%0b pending=%0d, want 0/0", last_ov, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        res_t prev_got = '0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(), rnd_operand(),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            if (prev_stall) begin
                n_tests++;
                if (last_ov !== 1'b1 || last_got !== prev_got) begin
                    n_fail++;
                    $display("FAIL rand_stable_%0d: got ov=%0b out=%h, want 1 %h",
                             i, last_ov, last_got, prev_got);
                end
            end
            if (last_fire) begin
                n_tests++;
                if (last_got !== last_exp) begin
                    n_fail++;
                    $display("FAIL rand_txn_%0d: got %h, want %h", i, last_got, last_exp);
                end
            end
            prev_stall = last_ov && !out_ready;
            prev_got   = last_got;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, '0, '0, 1'b1);
            if (last_fire) begin
                n_tests++;
                if (last_got !== last_exp) begin
                    n_fail++;
                    $display("FAIL rand_drain_%0d: got %h, want %h", i, last_got, last_exp);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: got %0d ops never emerged, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic e, l;
        res_t g, m;
        step(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h0, 3'd0, 1'b0);
        step(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 3'd2, 1'b0);
        step(1'b1, 32'h7FC0_0000, 32'h0, 32'h0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sample() !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got ov=%0b out=%h, want 0 and zero", out_valid, sample());
        end
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: got ir=%0b ov=%0b, want 1/0", in_ready, out_valid);
        end
        run_one(32'h0000_0000, 32'hFF80_0000, 32'h0, 3'd2, e, l, g, m);
        n_tests++;
        if (!l || g !== m || g.inv !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_op: got fire=%0b out=%h, want %h", l, g, m);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
